// File: rtl/svc_rv_ext_fp_csr.sv
// RV32F fflags/frm/fcsr CSR block: combinational reads, state updates on the next clk; never stalls.
// Optional mstatus.FS dirty tracking built when SVC_RV_EXT_FP_FS_TRACK_EN is defined.
module svc_rv_ext_fp_csr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_result_valid,
  input  logic [4:0]  ex_fflags,
  input  logic        ex_retire,
  input  logic        ex_fp_wr,
  input  logic        csr_valid,
  input  logic [11:0] csr_addr,
  input  logic [1:0]  csr_op,
  input  logic        csr_wr_en,
  input  logic [31:0] csr_wdata,
  output logic        csr_hit,
  output logic [31:0] csr_rdata,
  output logic [2:0]  frm_csr,
  output logic        frm_invalid,
  output logic [4:0]  fflags,
  input  logic        mstatus_fs_wr,
  input  logic [1:0]  mstatus_fs_wdata,
  output logic [1:0]  fs_state
);

  logic [4:0]  fflags_q, fflags_d;
  logic [2:0]  frm_q, frm_d;
  logic        accruing;
  logic [4:0]  flags_view;
  logic        sel_fflags, sel_frm, sel_fcsr;
  logic        csr_wr, fflags_wr, frm_wr;
  logic [31:0] new_val;

  assign accruing   = ex_result_valid && ex_retire;
  // The retiring FP op is older than the CSR instruction, so reads see its flags.
  assign flags_view = fflags_q | (accruing ? ex_fflags : 5'd0);

  assign sel_fflags = (csr_addr == 12'h001);
  assign sel_frm    = (csr_addr == 12'h002);
  assign sel_fcsr   = (csr_addr == 12'h003);
  assign csr_hit    = csr_valid && (sel_fflags || sel_frm || sel_fcsr);

  always_comb begin
    csr_rdata = 32'd0;
    if (csr_hit) begin
      if (sel_fflags)   csr_rdata = {27'd0, flags_view};
      else if (sel_frm) csr_rdata = {29'd0, frm_q};
      else              csr_rdata = {24'd0, frm_q, flags_view};
    end
  end

  always_comb begin
    new_val = csr_rdata;
    case (csr_op)
      2'b01:   new_val = csr_wdata;
      2'b10:   new_val = csr_rdata | csr_wdata;
      2'b11:   new_val = csr_rdata & ~csr_wdata;
      default: new_val = csr_rdata;
    endcase
  end

  assign csr_wr    = csr_hit && csr_wr_en && (csr_op != 2'b00);
  assign fflags_wr = csr_wr && (sel_fflags || sel_fcsr);
  assign frm_wr    = csr_wr && (sel_frm || sel_fcsr);

  // A CSR write already folds in same-cycle accrual through the old view.
  always_comb begin
    fflags_d = fflags_q;
    if (fflags_wr)     fflags_d = new_val[4:0];
    else if (accruing) fflags_d = flags_view;
  end

  always_comb begin
    frm_d = frm_q;
    if (csr_wr && sel_frm)       frm_d = new_val[2:0];
    else if (csr_wr && sel_fcsr) frm_d = new_val[7:5];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fflags_q <= 5'd0;
      frm_q    <= 3'd0;
    end else begin
      fflags_q <= fflags_d;
      frm_q    <= frm_d;
    end
  end

  assign fflags      = fflags_q;
  assign frm_csr     = frm_q;
  assign frm_invalid = (frm_q >= 3'd5);

  logic [23:0] unused_new_hi;
  assign unused_new_hi = new_val[31:8];

`ifdef SVC_RV_EXT_FP_FS_TRACK_EN
  typedef enum logic [1:0] {
    FS_OFF     = 2'b00,
    FS_INITIAL = 2'b01,
    FS_CLEAN   = 2'b10,
    FS_DIRTY   = 2'b11
  } fs_e;

  fs_e  fs_q, fs_d;
  logic hw_dirty;

  assign hw_dirty = (accruing && (|ex_fflags)) || (accruing && ex_fp_wr)
                  || fflags_wr || frm_wr;

  // Off is sticky against hardware activity; only an mstatus write leaves it.
  always_comb begin
    fs_d = fs_q;
    if (mstatus_fs_wr) begin
      if (hw_dirty && (mstatus_fs_wdata != 2'b00)) fs_d = FS_DIRTY;
      else                                         fs_d = fs_e'(mstatus_fs_wdata);
    end else if (hw_dirty && (fs_q != FS_OFF)) begin
      fs_d = FS_DIRTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fs_q <= FS_INITIAL;
    else        fs_q <= fs_d;
  end

  assign fs_state = fs_q;
`else
  logic unused_fs;
  assign unused_fs = &{1'b0, mstatus_fs_wr, mstatus_fs_wdata, ex_fp_wr};
  assign fs_state  = 2'b11;
`endif

endmodule

// File: tb/tb_svc_rv_ext_fp_csr.sv
// Directed plus randomized bench for svc_rv_ext_fp_csr against a field-level reference model.
module tb_svc_rv_ext_fp_csr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_result_valid;
  logic [4:0]  ex_fflags;
  logic        ex_retire;
  logic        ex_fp_wr;
  logic        csr_valid;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic        csr_wr_en;
  logic [31:0] csr_wdata;
  logic        csr_hit;
  logic [31:0] csr_rdata;
  logic [2:0]  frm_csr;
  logic        frm_invalid;
  logic [4:0]  fflags;
  logic        mstatus_fs_wr;
  logic [1:0]  mstatus_fs_wdata;
  logic [1:0]  fs_state;

  always #5 clk = ~clk;

`ifdef SVC_RV_EXT_FP_FS_TRACK_EN
  localparam logic [1:0] FS_RST = 2'b01;
`else
  localparam logic [1:0] FS_RST = 2'b11;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // reference model state and per-cycle scratch
  logic [4:0]  m_fflags;
  logic [2:0]  m_frm;
  logic [1:0]  m_fs;
  logic [4:0]  r_acc, r_ff_nx;
  logic [2:0]  r_frm_nx;
  logic [1:0]  r_fs_nx;
  logic [31:0] r_rd, r_new;
  logic        r_hit, r_wr, r_dirty;

  svc_rv_ext_fp_csr dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ex_result_valid  (ex_result_valid),
    .ex_fflags        (ex_fflags),
    .ex_retire        (ex_retire),
    .ex_fp_wr         (ex_fp_wr),
    .csr_valid        (csr_valid),
    .csr_addr         (csr_addr),
    .csr_op           (csr_op),
    .csr_wr_en        (csr_wr_en),
    .csr_wdata        (csr_wdata),
    .csr_hit          (csr_hit),
    .csr_rdata        (csr_rdata),
    .frm_csr          (frm_csr),
    .frm_invalid      (frm_invalid),
    .fflags           (fflags),
    .mstatus_fs_wr    (mstatus_fs_wr),
    .mstatus_fs_wdata (mstatus_fs_wdata),
    .fs_state         (fs_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ex_result_valid  = 1'b0;
    ex_fflags        = 5'd0;
    ex_retire        = 1'b0;
    ex_fp_wr         = 1'b0;
    csr_valid        = 1'b0;
    csr_addr         = 12'd0;
    csr_op           = 2'b00;
    csr_wr_en        = 1'b0;
    csr_wdata        = 32'd0;
    mstatus_fs_wr    = 1'b0;
    mstatus_fs_wdata = 2'b00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr(input logic [11:0] a, input logic [1:0] op, input logic we,
                     input logic [31:0] wd);
    csr_valid = 1'b1;
    csr_addr  = a;
    csr_op    = op;
    csr_wr_en = we;
    csr_wdata = wd;
  endtask

  task automatic retire(input logic [4:0] f, input logic fpw);
    ex_result_valid = 1'b1;
    ex_retire       = 1'b1;
    ex_fflags       = f;
    ex_fp_wr        = fpw;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #2;
    check("rst_hit", csr_hit, 0);
    check("rst_rdata", csr_rdata, 0);
    check("rst_frm_invalid", frm_invalid, 0);
    check("rst_frm", frm_csr, 0);
    check("rst_fflags", fflags, 0);
    check("rst_fs", fs_state, FS_RST);
    tick();
    rst_n = 1'b1;
    tick();

    csr(12'h003, 2'b00, 1'b0, 32'd0);
    #1;
    check("rd_fcsr_hit", csr_hit, 1);
    check("rd_fcsr_rst", csr_rdata, 0);
    tick(); idle();

    // accrual across two retiring ops, then a flushed one
    retire(5'b01000, 1'b1); tick();
    retire(5'b00001, 1'b1); tick(); idle();
    csr(12'h001, 2'b00, 1'b0, 32'd0);
    #1;
    check("accrue_read", csr_rdata, 32'h09);
    ex_result_valid = 1'b1; ex_retire = 1'b0; ex_fflags = 5'b10000;
    #1;
    check("flushed_read", csr_rdata, 32'h09);
    tick(); idle();
    check("flushed_state", fflags, 5'h09);

    // frm write visible only next cycle
    csr(12'h002, 2'b01, 1'b1, 32'd1);
    #1;
    check("frm_rw_old", csr_rdata, 0);
    check("frm_same_cycle", frm_csr, 0);
    tick(); idle();
    check("frm_rtz", frm_csr, 3'd1);
    check("frm_valid", frm_invalid, 0);
    csr(12'h002, 2'b01, 1'b1, 32'd5);
    tick(); idle();
    check("frm_5", frm_csr, 3'd5);
    check("frm_invalid", frm_invalid, 1);

    csr(12'h001, 2'b01, 1'b1, 32'd0);
    tick(); idle();
    check("fflags_clear", fflags, 0);

    // CSR write and accrual in the same cycle
    csr(12'h001, 2'b11, 1'b1, 32'h1F);
    retire(5'b00001, 1'b0);
    #1;
    check("rc_same_read", csr_rdata, 32'h01);
    tick(); idle();
    check("rc_same_state", fflags, 0);
    csr(12'h001, 2'b10, 1'b1, 32'h10);
    retire(5'b00001, 1'b0);
    #1;
    check("rs_same_read", csr_rdata, 32'h01);
    tick(); idle();
    check("rs_same_state", fflags, 5'h11);

    // RS with write disabled is a pure read
    csr(12'h003, 2'b10, 1'b0, 32'hFF);
    #1;
    check("fcsr_read", csr_rdata, 32'hB1);
    tick(); idle();
    check("ro_fflags", fflags, 5'h11);
    check("ro_frm", frm_csr, 3'd5);
    csr(12'h003, 2'b01, 1'b1, 32'hE5);
    tick(); idle();
    check("fcsr_frm", frm_csr, 3'd7);
    check("fcsr_fflags", fflags, 5'h05);
    csr(12'h300, 2'b01, 1'b1, 32'hFFFF_FFFF);
    #1;
    check("miss_hit", csr_hit, 0);
    check("miss_rdata", csr_rdata, 0);
    tick(); idle();
    check("miss_no_write", fflags, 5'h05);

`ifdef SVC_RV_EXT_FP_FS_TRACK_EN
    mstatus_fs_wr = 1'b1; mstatus_fs_wdata = 2'b10;
    tick(); idle();
    check("fs_clean", fs_state, 2'b10);
    retire(5'd0, 1'b1);
    tick(); idle();
    check("fs_dirty_fpwr", fs_state, 2'b11);
    mstatus_fs_wr = 1'b1; mstatus_fs_wdata = 2'b00;
    retire(5'h1F, 1'b1);
    tick(); idle();
    check("fs_off_wins", fs_state, 2'b00);
    retire(5'h1F, 1'b1);
    csr(12'h002, 2'b01, 1'b1, 32'd2);
    tick(); idle();
    check("fs_off_sticky", fs_state, 2'b00);
    mstatus_fs_wr = 1'b1; mstatus_fs_wdata = 2'b01;
    tick(); idle();
    check("fs_initial", fs_state, 2'b01);
    mstatus_fs_wr = 1'b1; mstatus_fs_wdata = 2'b10;
    retire(5'h02, 1'b0);
    tick(); idle();
    check("fs_clean_dirty", fs_state, 2'b11);
`else
    retire(5'h1F, 1'b1);
    mstatus_fs_wr = 1'b1; mstatus_fs_wdata = 2'b00;
    tick(); idle();
    check("fs_tied", fs_state, 2'b11);
`endif

    // asynchronous reset in the middle of a cycle
    retire(5'h1F, 1'b1);
    csr(12'h003, 2'b01, 1'b1, 32'hFF);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_fflags", fflags, 0);
    check("arst_frm", frm_csr, 0);
    check("arst_fs", fs_state, FS_RST);
    tick();
    check("arst_hold", fflags, 0);
    idle();
    rst_n = 1'b1;
    m_fflags = 5'd0;
    m_frm    = 3'd0;
    m_fs     = FS_RST;

    for (int i = 0; i < 400; i++) begin
      ex_result_valid = 1'($urandom_range(0, 1));
      ex_retire       = ($urandom_range(0, 3) != 0);
      ex_fflags       = 5'($urandom);
      ex_fp_wr        = 1'($urandom_range(0, 1));
      csr_valid       = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0:       csr_addr = 12'h001;
        1:       csr_addr = 12'h002;
        2:       csr_addr = 12'h003;
        3:       csr_addr = 12'h300;
        default: csr_addr = 12'($urandom);
      endcase
      csr_op           = 2'($urandom);
      csr_wr_en        = 1'($urandom_range(0, 1));
      csr_wdata        = $urandom;
      mstatus_fs_wr    = ($urandom_range(0, 7) == 0);
      mstatus_fs_wdata = 2'($urandom);

      r_acc = (ex_result_valid && ex_retire) ? ex_fflags : 5'd0;
      r_hit = csr_valid && (csr_addr >= 12'd1) && (csr_addr <= 12'd3);
      r_rd  = 32'd0;
      if (r_hit) begin
        if (csr_addr == 12'd1)      r_rd = 32'(m_fflags | r_acc);
        else if (csr_addr == 12'd2) r_rd = 32'(m_frm);
        else                        r_rd = 32'(m_frm) * 32 + 32'(m_fflags | r_acc);
      end
      case (csr_op)
        2'd1:    r_new = csr_wdata;
        2'd2:    r_new = r_rd | csr_wdata;
        2'd3:    r_new = r_rd & ~csr_wdata;
        default: r_new = r_rd;
      endcase
      r_wr     = r_hit && csr_wr_en && (csr_op != 2'd0);
      r_ff_nx  = (r_wr && csr_addr != 12'd2) ? r_new[4:0] : (m_fflags | r_acc);
      r_frm_nx = m_frm;
      if (r_wr && csr_addr == 12'd2) r_frm_nx = r_new[2:0];
      if (r_wr && csr_addr == 12'd3) r_frm_nx = r_new[7:5];
      r_dirty  = (r_acc != 5'd0) || (ex_result_valid && ex_retire && ex_fp_wr) || r_wr;
`ifdef SVC_RV_EXT_FP_FS_TRACK_EN
      r_fs_nx = m_fs;
      if (mstatus_fs_wr)                    r_fs_nx = (r_dirty && mstatus_fs_wdata != 2'd0) ? 2'd3 : mstatus_fs_wdata;
      else if (r_dirty && m_fs != 2'd0)     r_fs_nx = 2'd3;
`else
      r_fs_nx = 2'd3;
`endif

      #1;
      check("rnd_hit", csr_hit, r_hit);
      check("rnd_rdata", csr_rdata, r_rd);
      check("rnd_frm_invalid", frm_invalid, (m_frm >= 3'd5));
      tick();
      m_fflags = r_ff_nx;
      m_frm    = r_frm_nx;
      m_fs     = r_fs_nx;
      check("rnd_fflags", fflags, m_fflags);
      check("rnd_frm", frm_csr, m_frm);
      check("rnd_fs", fs_state, m_fs);
    end

    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/svc_rv_ext_fp_csr.md
# svc_rv_ext_fp_csr

Floating-point control/status register block for the RV32F extension. It sits directly downstream of the FP execute stage, where it accrues that stage's `fflags` from retiring FP operations. It sits upstream of the same stage as well, supplying `frm_csr` for dynamic rounding. It owns the `fflags`, `frm` and `fcsr` user CSRs and optionally the `mstatus.FS` dirty-tracking state.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ex_result_valid  in  1  FP execute stage has a completed result this cycle
- ex_fflags  in  5  exception flags of that result {NV,DZ,OF,UF,NX}
- ex_retire  in  1  completing op commits (not flushed); accrual requires `ex_result_valid && ex_retire`
- ex_fp_wr  in  1  committing op writes an FP register
- csr_valid  in  1  CSR instruction executing this cycle
- csr_addr  in  12  CSR address
- csr_op  in  2  01 = RW, 10 = RS, 11 = RC, 00 = read only
- csr_wr_en  in  1  write side effect enabled (decoder clears it for RS/RC with x0 source)
- csr_wdata  in  32  source operand
- csr_hit  out  1  `csr_valid` and address ∈ {0x001, 0x002, 0x003}
- csr_rdata  out  32  read value, zero-extended; 0 when not hit
- frm_csr  out  3  current rounding mode, to the FP execute stage
- frm_invalid  out  1  `frm_csr` ∈ {5, 6, 7}; with `FRM_DYN` this is an illegal instruction
- fflags  out  5  current accrued flags
- mstatus_fs_wr  in  1  `mstatus` write targeting FS
- mstatus_fs_wdata  in  2  FS write value
- fs_state  out  2  `mstatus.FS`

## Operation
- Storage: `fflags_q[4:0]`, `frm_q[2:0]`, and `fs_q[1:0]` (the last only under the macro).
- Read view, combinational:
  - `flags_view = fflags_q | acc`, where `acc = ex_fflags` if accruing, else 0.
  - The same-cycle retiring FP op is older than the CSR instruction, so a CSR read sees its flags.
- `csr_rdata` by address:
  - 0x001 → `{27'b0, flags_view}`
  - 0x002 → `{29'b0, frm_q}`
  - 0x003 → `{24'b0, frm_q, flags_view}`
- Write value: `old` is the field view above. RW: `new = wdata`. RS: `new = old | wdata`. RC: `new = old & ~wdata`. Only the implemented bits are used; others are ignored.
- Next state:
  - `fflags_q`: CSR write to 0x001/0x003 → `new[4:0]`, which already includes the same-cycle accrual through `old`. Else if accruing → `fflags_q | ex_fflags`. Else hold.
  - `frm_q`: CSR write to 0x002 → `new[2:0]`; to 0x003 → `new[7:5]`.
  - A write requires `csr_hit && csr_wr_en && csr_op != 00`.
- The block never reports errors itself; reserved `frm` values are stored and flagged through `frm_invalid`.
- FS state machine (macro enabled): states Off 00, Initial 01, Clean 10, Dirty 11.
  - `hw_dirty` = accruing with nonzero `ex_fflags`, or `ex_result_valid && ex_retire && ex_fp_wr`, or any fflags/frm CSR write.
  - If `mstatus_fs_wr`: the next state is `mstatus_fs_wdata`, except Dirty when `hw_dirty` and wdata ≠ Off.
  - Else if `hw_dirty` and `fs_q` ≠ Off: next state is Dirty.
  - Else hold.
  - In state Off, nothing sets Dirty. Trapping FP instructions while Off is the decoder's job.

## Timing
- Reset values: `fflags_q` = 0, `frm_q` = 0 (RNE), `fs_q` = 01 (Initial).
- Reset outputs: `csr_rdata` = 0, `csr_hit` = 0, `frm_invalid` = 0.
- `csr_rdata`, `csr_hit`, `frm_invalid` and `fflags` are combinational from the current state and inputs. All register updates occur on the next rising `clk`.
- `frm_csr` reflects a write one cycle after the write cycle. There is no bypass; the pipeline must not issue a dynamic-rm FP op in the same cycle as an `frm` write.
- Accrual, CSR write and FS update happen in the same cycle, with the priority defined above.
- Asserting `rst_n` low mid-operation clears all state immediately. Inputs are ignored while reset is asserted.

## Configuration
- Macro `SVC_RV_EXT_FP_FS_TRACK_EN`.
- Defined: the FS state machine above is built, and `fs_state = fs_q`.
- Undefined: there is no FS register, `fs_state` is tied to 2'b11 (Dirty), and `mstatus_fs_wr`, `mstatus_fs_wdata` and `ex_fp_wr` are ignored. `fflags`/`frm` behaviour is unchanged.

## Test plan
- Reset, then read 0x003 → `csr_rdata` = 0, `frm_csr` = 0, `fs_state` = 01 (with macro) or 11 (without).
- Retire FDIV with `ex_fflags` = 01000, then FADD with 00001, then read 0x001 → 0x09. A flushed op (`ex_retire` = 0) with 10000 leaves it at 0x09.
- CSRRW 0x002 ← 1 (RTZ) → `frm_csr` = 1 on the next cycle, not the same cycle. CSRRW 0x002 ← 5 → `frm_invalid` = 1.
- Same cycle: retiring op with `ex_fflags` = 00001 plus CSRRC 0x001 with `wdata` = 0x1F → `csr_rdata` = 0x01 and `fflags` = 0 afterwards. Same cycle with CSRRS `wdata` = 0x10 instead → `fflags` = 0x11.
- CSRRS 0x003 with `csr_wr_en` = 0 → read only, state unchanged. CSRRW 0x003 ← 0xE5 → `frm_csr` = 7, `fflags` = 0x05. Read of address 0x300 → `csr_hit` = 0, `csr_rdata` = 0.
- With macro: `mstatus_fs_wr` = Clean, then an FP register write retires → Dirty. `mstatus_fs_wr` = Off with simultaneous `hw_dirty` → Off, and later retirements keep it Off.
